// File: rtl/baud_tick_gen_os_if.sv
// Control and tick bundle for the baud tick generator.
// master drives configuration/strobes, slave (the generator) returns ticks and status.
interface baud_tick_gen_os_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
);
    logic              en;
    logic              sync_clr;
    logic              load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              os_tick;
    logic              bit_tick;
    logic              mid_tick;
    logic              cfg_err;

    modport master (
        output en, sync_clr, load, div_int, div_frac,
        input  os_tick, bit_tick, mid_tick, cfg_err
    );

    modport slave (
        input  en, sync_clr, load, div_int, div_frac,
        output os_tick, bit_tick, mid_tick, cfg_err
    );
endinterface

// File: rtl/baud_tick_gen_os.sv
// Baud tick generator: oversample, bit and mid-bit ticks from a runtime divisor.
// Optional fractional divisor enabled by defining BAUD_FRAC_EN.
module baud_tick_gen_os #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned OSR     = 16,
    parameter int unsigned DEF_DIV = 27,
    parameter int unsigned FRAC_W  = 4
) (
    input logic              clk,
    input logic              rst_n,
    baud_tick_gen_os_if.slave bus
);

    localparam int unsigned OsW = $clog2(OSR);
    localparam logic [OsW-1:0] OsLast = OsW'(OSR - 1);
    localparam logic [OsW-1:0] OsMid  = OsW'(OSR / 2);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [OsW-1:0]   os_cnt_q, os_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             os_tick_q, os_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             mid_tick_q, mid_tick_d;
    logic             cfg_err_q, cfg_err_d;

    logic period_long;
    logic wrap;
    logic apply;
    logic load_ok;

    assign load_ok = bus.load && (bus.div_int != '0);
    // A long (fractional-carry) period ends one count later.
    assign wrap    = bus.en && !bus.sync_clr &&
                     (period_long ? (cnt_q == div_q) : (cnt_q == div_q - 1'b1));
    assign apply   = pend_q && (wrap || !bus.en || bus.sync_clr);

    always_comb begin
        cnt_d      = cnt_q;
        os_cnt_d   = os_cnt_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        mid_tick_d = 1'b0;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        cfg_err_d  = cfg_err_q;

        if (bus.sync_clr) begin
            cnt_d    = '0;
            os_cnt_d = '0;
        end else if (bus.en) begin
            if (wrap) begin
                cnt_d      = '0;
                os_tick_d  = 1'b1;
                os_cnt_d   = (os_cnt_q == OsLast) ? '0 : os_cnt_q + 1'b1;
                bit_tick_d = (os_cnt_q == OsLast);
                mid_tick_d = (os_cnt_d == OsMid);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (apply) begin
            div_d  = pend_div_q;
            pend_d = 1'b0;
        end

        // A load on the apply edge becomes the new pending value.
        if (bus.load) begin
            if (load_ok) begin
                pend_d     = 1'b1;
                pend_div_d = bus.div_int;
                cfg_err_d  = 1'b0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            os_cnt_q   <= '0;
            div_q      <= DIV_W'(DEF_DIV);
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            mid_tick_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            os_cnt_q   <= os_cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
            mid_tick_q <= mid_tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              long_q, long_d;

    assign period_long = long_q;

    always_comb begin
        frac_d      = frac_q;
        pend_frac_d = pend_frac_q;
        acc_d       = acc_q;
        long_d      = long_q;

        if (bus.sync_clr) begin
            acc_d  = '0;
            long_d = 1'b0;
        end else if (wrap) begin
            // Carry out of the accumulator stretches the next period by one cycle.
            {long_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_q};
        end

        if (apply) begin
            frac_d = pend_frac_q;
        end
        if (load_ok) begin
            pend_frac_d = bus.div_frac;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_q      <= '0;
            pend_frac_q <= '0;
            acc_q       <= '0;
            long_q      <= 1'b0;
        end else begin
            frac_q      <= frac_d;
            pend_frac_q <= pend_frac_d;
            acc_q       <= acc_d;
            long_q      <= long_d;
        end
    end
`else
    logic unused_div_frac;

    assign period_long     = 1'b0;
    assign unused_div_frac = ^bus.div_frac;
`endif

    assign bus.os_tick  = os_tick_q;
    assign bus.bit_tick = bit_tick_q;
    assign bus.mid_tick = mid_tick_q;
    assign bus.cfg_err  = cfg_err_q;

endmodule
